// File: rtl/timer_pkg.sv
// timer_pkg
// Shared definitions for the bus timer peripheral and its bus decoder:
//   - default base address of the register window
//   - register word offsets (byte offset >> 2; addr[1:0] is ignored)
//   - TCON bit positions and register reset values
//   - helper to assemble the TCON read word
package timer_pkg;

  // Default word-aligned base of the 6-word register window.
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  // Word offsets inside the window (compared against addr[4:2]).
  localparam logic [2:0] OFF_TH      = 3'd0;  // 0x00
  localparam logic [2:0] OFF_TL      = 3'd1;  // 0x04
  localparam logic [2:0] OFF_TCON    = 3'd2;  // 0x08
  localparam logic [2:0] OFF_SYSTICK = 3'd5;  // 0x14
  localparam logic [2:0] OFF_LAST    = 3'd5;  // highest word that still hits

  // TCON bit indices.
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IF = 2;

  // Reset values.
  localparam logic [31:0] TH_RESET      = 32'h0000_0000;
  localparam logic [31:0] TL_RESET      = 32'h0000_0000;
  localparam logic [31:0] SYSTICK_RESET = 32'h0000_0000;
  localparam logic        TCON_RESET    = 1'b0;

  // TCON read word: bits[31:3] always read as zero.
  function automatic logic [31:0] tcon_word(input logic en, input logic ie, input logic iflag);
    tcon_word = {29'd0, iflag, ie, en};
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler
// Divides clk by PRESCALE while enabled and emits a one-cycle tick at the
// end of every period.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   en    : timer enable; while low the count is parked at 0
//   tick  : high on the last cycle of each period (only while en=1)
module timer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] r_count;

  // Period counter: parks at 0 while disabled so a re-enable starts a full period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 16'd0;
    end else if (!en) begin
      r_count <= 16'd0;
    end else if (r_count == LAST) begin
      r_count <= 16'd0;
    end else begin
      r_count <= r_count + 16'd1;
    end
  end

  // Gated by en so PRESCALE=1 (count stuck at 0) does not tick while stopped.
  assign tick = en && (r_count == LAST);

endmodule

// File: rtl/bus_timer_responder.sv
// bus_timer_responder
// Memory-mapped timer on the CPU data bus (MEM stage load/store traffic).
// Registers: TH (reload), TL (counter), TCON (EN/IE/IF), SYSTICK (free-running).
//   clk        : system clock, rising edge
//   reset      : asynchronous active-high reset
//   addr       : byte address from EX/MEM ALU result
//   Mem_rd     : load strobe
//   Mem_wr     : store strobe
//   Write_data : store data
//   Read_data  : load data, combinational, 0 unless Mem_rd && hit
//   hit        : addr lies in the 6-word window (independent of strobes)
//   irq        : level interrupt request, IE & IF
module bus_timer_responder
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        Mem_rd,
  input  logic        Mem_wr,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic        hit,
  output logic        irq
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic        r_en;
  logic        r_ie;
  logic        r_if;
  logic [31:0] r_systick;

  logic [2:0]  w_idx;
  logic        w_hit;
  logic        w_tick;
  logic        w_wr_th;
  logic        w_wr_tl;
  logic        w_wr_tcon;
  logic        w_tl_max;
  logic        w_set_if;
  logic [31:0] w_rdata;
  logic        w_unused_addr_lsbs;

  assign w_idx = addr[4:2];
  assign w_hit = (addr[31:5] == BASE_ADDR[31:5]) && (w_idx <= OFF_LAST);
  assign hit   = w_hit;

  // Byte lane bits are don't-care for this word-only peripheral.
  assign w_unused_addr_lsbs = ^addr[1:0];

  assign w_wr_th   = Mem_wr && w_hit && (w_idx == OFF_TH);
  assign w_wr_tl   = Mem_wr && w_hit && (w_idx == OFF_TL);
  assign w_wr_tcon = Mem_wr && w_hit && (w_idx == OFF_TCON);

  timer_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (r_en),
    .tick (w_tick)
  );

  assign w_tl_max = (r_tl == 32'hFFFF_FFFF);
  // A TL store on the overflow edge cancels the overflow entirely, IF included.
  assign w_set_if = w_tick && w_tl_max && r_ie && !w_wr_tl;

  // Combinational read mux; registers still hold pre-write values this cycle.
  always_comb begin
    w_rdata = 32'd0;
    if (Mem_rd && w_hit) begin
      case (w_idx)
        OFF_TH:      w_rdata = r_th;
        OFF_TL:      w_rdata = r_tl;
        OFF_TCON:    w_rdata = tcon_word(r_en, r_ie, r_if);
        OFF_SYSTICK: w_rdata = r_systick;
        default:     w_rdata = 32'd0;
      endcase
    end else begin
      w_rdata = 32'd0;
    end
  end

  assign Read_data = w_rdata;

  // Reload register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_th <= TH_RESET;
    end else if (w_wr_th) begin
      r_th <= Write_data;
    end
  end

  // Counter: a store beats the tick; overflow reloads from the current (old) TH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tl <= TL_RESET;
    end else if (w_wr_tl) begin
      r_tl <= Write_data;
    end else if (w_tick) begin
      if (w_tl_max) begin
        r_tl <= r_th;
      end else begin
        r_tl <= r_tl + 32'd1;
      end
    end
  end

  // Control bits: EN/IE written directly; a tick in flight uses the old EN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en <= TCON_RESET;
      r_ie <= TCON_RESET;
    end else if (w_wr_tcon) begin
      r_en <= Write_data[TCON_EN];
      r_ie <= Write_data[TCON_IE];
    end
  end

  // Overflow flag: write-1-to-clear, but a simultaneous set wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_if <= TCON_RESET;
    end else if (w_set_if) begin
      r_if <= 1'b1;
    end else if (w_wr_tcon && Write_data[TCON_IF]) begin
      r_if <= 1'b0;
    end
  end

  // Free-running tick counter, wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_systick <= SYSTICK_RESET;
    end else begin
      r_systick <= r_systick + 32'd1;
    end
  end

  assign irq = r_ie && r_if;

endmodule

// File: tb/tb_bus_timer_responder.sv
// Directed self-checking bench for bus_timer_responder.
// u_dut1 uses PRESCALE=1, u_dut4 uses PRESCALE=4; both share clk, reset,
// addr, Mem_rd and Write_data, with separate store strobes.
module tb_bus_timer_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = 32'd0;
  logic        mem_rd = 1'b0;
  logic        wr1 = 1'b0;
  logic        wr4 = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata1;
  logic [31:0] rdata4;
  logic        hit1;
  logic        hit4;
  logic        irq1;
  logic        irq4;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_RSV  = 32'h4000_000C;
  localparam logic [31:0] A_SYS  = 32'h4000_0014;
  localparam logic [31:0] A_OUT  = 32'h4000_0018;

  bus_timer_responder #(.BASE_ADDR(32'h4000_0000), .PRESCALE(1)) u_dut1 (
    .clk(clk), .reset(reset), .addr(addr), .Mem_rd(mem_rd), .Mem_wr(wr1),
    .Write_data(wdata), .Read_data(rdata1), .hit(hit1), .irq(irq1)
  );

  bus_timer_responder #(.BASE_ADDR(32'h4000_0000), .PRESCALE(4)) u_dut4 (
    .clk(clk), .reset(reset), .addr(addr), .Mem_rd(mem_rd), .Mem_wr(wr4),
    .Write_data(wdata), .Read_data(rdata4), .hit(hit4), .irq(irq4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Store lands on the next rising edge; returns 1 time unit after it.
  task automatic wr(input bit sel4, input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    if (sel4) wr4 = 1'b1;
    else      wr1 = 1'b1;
    step();
    wr1 = 1'b0;
    wr4 = 1'b0;
  endtask

  // Combinational load, sampled 1 time unit after driving.
  task automatic rd(input bit sel4, input logic [31:0] a, input logic [31:0] exp, input string tag);
    addr   = a;
    mem_rd = 1'b1;
    #1;
    chk(tag, sel4 ? rdata4 : rdata1, exp);
    mem_rd = 1'b0;
  endtask

  initial begin
    // ---- 1: reset state, read map, hit window ----
    #1;
    chk("irq_in_reset", {31'd0, irq1}, 32'd0);
    rd(1'b0, A_TL, 32'd0, "tl_in_reset");
    step();
    reset = 1'b0;
    rd(1'b0, A_TH,   32'd0, "th_reset");
    rd(1'b0, A_TL,   32'd0, "tl_reset");
    rd(1'b0, A_TCON, 32'd0, "tcon_reset");
    rd(1'b0, A_SYS,  32'd0, "systick_reset");
    for (int i = 1; i <= 4; i++) begin
      step();
      rd(1'b0, A_SYS, 32'(i), "systick_count");
    end
    chk("irq_reset", {31'd0, irq1}, 32'd0);
    rd(1'b0, A_RSV, 32'd0, "reserved_read");
    chk("hit_reserved", {31'd0, hit1}, 32'd1);
    rd(1'b0, A_OUT, 32'd0, "outside_read");
    chk("hit_outside", {31'd0, hit1}, 32'd0);
    addr = 32'h4000_0020;
    #1;
    chk("hit_next_block", {31'd0, hit1}, 32'd0);
    mem_rd = 1'b0;
    addr   = A_SYS;
    #1;
    chk("hit_no_strobe", {31'd0, hit1}, 32'd1);
    chk("rdata_no_strobe", rdata1, 32'd0);

    // ---- 4: PRESCALE=4 timing, stop and restart ----
    wr(1'b1, A_TCON, 32'h1);
    step(); step(); step();
    rd(1'b1, A_TL, 32'd0, "ps4_before_first_tick");
    step();
    rd(1'b1, A_TL, 32'd1, "ps4_after_4");
    step(); step(); step(); step();
    rd(1'b1, A_TL, 32'd2, "ps4_after_8");
    step(); step(); step(); step();
    rd(1'b1, A_TL, 32'd3, "ps4_after_12");
    step();
    wr(1'b1, A_TCON, 32'h0);
    for (int i = 0; i < 6; i++) step();
    rd(1'b1, A_TL, 32'd3, "ps4_hold_when_disabled");
    wr(1'b1, A_TCON, 32'h1);
    step(); step(); step();
    rd(1'b1, A_TL, 32'd3, "ps4_restart_full_period");
    step();
    rd(1'b1, A_TL, 32'd4, "ps4_restart_tick");

    // ---- 2: overflow with reload and IF ----
    wr(1'b0, A_TH,   32'hFFFF_FFF0);
    wr(1'b0, A_TL,   32'hFFFF_FFFE);
    wr(1'b0, A_TCON, 32'h3);
    rd(1'b0, A_TL, 32'hFFFF_FFFE, "tl_after_store");
    step();
    rd(1'b0, A_TL, 32'hFFFF_FFFF, "tl_max");
    chk("irq_before_wrap", {31'd0, irq1}, 32'd0);
    step();
    rd(1'b0, A_TL,   32'hFFFF_FFF0, "tl_reloaded");
    rd(1'b0, A_TCON, 32'h7,         "tcon_if_set");
    chk("irq_after_wrap", {31'd0, irq1}, 32'd1);

    // ---- 3: IF clear, clear racing overflow, EN=0 racing tick ----
    wr(1'b0, A_TCON, 32'h7);
    chk("irq_cleared", {31'd0, irq1}, 32'd0);
    rd(1'b0, A_TCON, 32'h3,         "tcon_if_cleared");
    rd(1'b0, A_TL,   32'hFFFF_FFF1, "tl_counts_through_clear");
    step();
    rd(1'b0, A_TL,   32'hFFFF_FFF2, "tl_keeps_counting");
    wr(1'b0, A_TL, 32'hFFFF_FFFE);
    step();
    rd(1'b0, A_TL, 32'hFFFF_FFFF, "tl_max_again");
    wr(1'b0, A_TCON, 32'h7);
    chk("irq_set_beats_clear", {31'd0, irq1}, 32'd1);
    rd(1'b0, A_TCON, 32'h7,         "tcon_set_beats_clear");
    rd(1'b0, A_TL,   32'hFFFF_FFF0, "tl_reload_on_race");
    wr(1'b0, A_TCON, 32'h0);
    chk("irq_ie_cleared", {31'd0, irq1}, 32'd0);
    rd(1'b0, A_TCON, 32'h4,         "tcon_if_kept_on_w0");
    rd(1'b0, A_TL,   32'hFFFF_FFF1, "tl_tick_completes");
    step();
    rd(1'b0, A_TL,   32'hFFFF_FFF1, "tl_stopped");
    wr(1'b0, A_TCON, 32'h4);
    rd(1'b0, A_TCON, 32'h0, "tcon_w1c");

    // ---- 5: store vs tick, read-before-write, TH store at overflow ----
    wr(1'b0, A_TCON, 32'h1);
    wr(1'b0, A_TL, 32'h0000_1234);
    rd(1'b0, A_TL, 32'h0000_1234, "tl_store_beats_tick");
    step();
    rd(1'b0, A_TL, 32'h0000_1235, "tl_inc_after_store");
    addr   = A_TH;
    wdata  = 32'hAAAA_5555;
    wr1    = 1'b1;
    mem_rd = 1'b1;
    #1;
    chk("th_read_before_write", rdata1, 32'hFFFF_FFF0);
    mem_rd = 1'b0;
    step();
    wr1 = 1'b0;
    rd(1'b0, A_TH, 32'hAAAA_5555, "th_after_write");
    wr(1'b0, A_TL, 32'hFFFF_FFFE);
    step();
    wr(1'b0, A_TH, 32'h0000_0100);
    rd(1'b0, A_TL,   32'hAAAA_5555, "reload_uses_old_th");
    rd(1'b0, A_TH,   32'h0000_0100, "th_new_value");
    rd(1'b0, A_TCON, 32'h1,         "no_if_without_ie");

    // ---- 6: asynchronous reset mid-count ----
    wr(1'b0, A_TCON, 32'h3);
    wr(1'b0, A_TL, 32'hFFFF_FFFF);
    step();
    chk("irq_before_reset", {31'd0, irq1}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("irq_async_reset", {31'd0, irq1}, 32'd0);
    rd(1'b0, A_TL,   32'd0, "tl_async_reset");
    rd(1'b0, A_TCON, 32'd0, "tcon_async_reset");
    rd(1'b0, A_SYS,  32'd0, "systick_async_reset");
    rd(1'b1, A_TL,   32'd0, "tl4_async_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_timer_responder.md
Name: bus_timer_responder

Overview:
Memory-mapped timer peripheral on the CPU data bus; it answers the load/store traffic the MEM stage issues.
- Registers: reload (TH), counter (TL), control/status (TCON) and a free-running system tick (SYSTICK).
- Raises a level interrupt request when TL overflows, if interrupts are enabled.
- Sits beside data memory; the bus decoder selects it via its hit output.

Parameters:
BASE_ADDR, 32'h4000_0000, word-aligned base of the register window
PRESCALE, 1, clk cycles per TL increment (legal range 1..65535)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
addr  input  32  byte address from EX/MEM ALU result
Mem_rd  input  1  load strobe for this cycle
Mem_wr  input  1  store strobe for this cycle
Write_data  input  32  store data (forwarded rt data)
Read_data  output  32  load data, combinational
hit  output  1  addr falls inside the 6-word window
irq  output  1  interrupt request, level

Behaviour:
Register map (offset from BASE_ADDR; addr[1:0] ignored):
- 0x00 TH: R/W
- 0x04 TL: R/W
- 0x08 TCON: bit0 EN, bit1 IE, bit2 IF; bits[31:3] read 0
- 0x0C, 0x10: reserved; read 0, writes ignored; hit still 1
- 0x14 SYSTICK: read-only; writes ignored

Reset (asynchronous) sets TH=0, TL=0, TCON=0, SYSTICK=0 and the prescale counter to 0. Outputs during reset: irq=0; Read_data follows the read mux, so it reads 0 for in-window addresses.

Read path:
- Combinational, zero latency, same cycle as Mem_rd.
- Read_data = 0 when Mem_rd=0 or hit=0.
- If Mem_rd and Mem_wr are both set, the read returns the pre-write value.

Write path:
- Takes effect at the rising edge while Mem_wr=1 and hit=1.
- TH and TL take Write_data directly.
- TCON write: EN and IE take Write_data[1:0]. IF is write-1-to-clear from Write_data[2]; writing 0 to bit2 leaves IF unchanged.

Prescaler:
- Counter runs 0..PRESCALE-1 while EN=1; tick = (count==PRESCALE-1).
- When EN=0 the counter holds at 0.
- PRESCALE=1 gives tick every cycle while EN=1.
- Clearing EN then setting it again restarts a full prescale period.

Counter on tick:
- If TL==32'hFFFF_FFFF: TL<=TH, and IF<=1 if IE=1.
- Otherwise TL<=TL+1, wrapping modulo 2^32 only via the reload path.

SYSTICK: increments by 1 every clk regardless of EN; wraps 32'hFFFF_FFFF -> 0.

irq = IE & IF, registered-state derived with no combinational path from the bus. It holds until IF is cleared or IE is cleared.

Simultaneous events:
- Store to TL and tick in the same cycle: the store wins; no increment, no reload, no IF set.
- Store to TH at overflow: the reload uses the old TH.
- TCON store clearing IF at the same edge as an overflow that sets it: set wins, IF=1.
- TCON store writing EN=0 at the same edge as a tick: the tick completes, then the timer stops.

hit = addr[31:5]==BASE_ADDR[31:5] && addr[4:2]<=3'd5. This is independent of Mem_rd/Mem_wr.

Decomposition:
- Shared package timer_pkg:
  - register offset constants: OFF_TH, OFF_TL, OFF_TCON, OFF_SYSTICK
  - TCON bit indices: TCON_EN=0, TCON_IE=1, TCON_IF=2
  - reset values
  - the default base address, which the bus decoder also uses
- One sub-module, timer_prescaler: PRESCALE parameter; inputs clk, reset, en; output tick.
- Register file, read mux and overflow logic stay in the top.

Test Plan:
1. Reset, then read 0x4000_0000/04/08/14 on successive cycles -> read values 0, 0, 0, 1..4; irq=0; a read at 0x4000_0018 -> hit=0, Read_data=0.
2. Write TH=32'hFFFF_FFF0, TL=32'hFFFF_FFFE, TCON=3 (PRESCALE=1) -> TL reads FFFF_FFFF the next cycle, then FFFF_FFF0; IF=1 and irq=1 on the cycle after the wrap.
3. With irq=1, write TCON=32'h7 -> IF cleared, irq=0; TL keeps counting. Repeat the clear on the exact overflow edge -> IF stays 1.
4. PRESCALE=4, EN=1 from TL=0 -> TL reaches 1 after 4 cycles and 3 after 12 cycles. Clear EN at cycle 6 -> TL holds at 1.
5. Store TL=32'h1234 on a tick edge -> the next read is 32'h1234, not 32'h1235. Same-cycle Mem_rd+Mem_wr to TH returns the old TH.
6. Assert reset mid-count with IF=1 -> irq, TL, TCON and SYSTICK are 0 immediately, without waiting for a clock edge.
